// File: rtl/prefetcher_queue_ctrl.sv
// Shares the prefetch queue port among R data, CPU lookups and stride prefetch issue (priority in that order).
// CPU result one cycle after accept; lookups stall while a block is outstanding, prefetch stalls on AR, occupancy and outstanding limits.
module prefetcher_queue_ctrl #(
    parameter int BA_ADDR_SIZE         = 64,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int LOG_QUEUE_SIZE       = 6,
    parameter int CNT_WIDTH            = 32,
    localparam int BLK = (1 << LOG_BLOCK_DATA_BYTES) * 8
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      cpuReqValid,
    input  logic [BA_ADDR_SIZE-1:0]   cpuReqAddr,
    output logic                      cpuReqReady,
    output logic                      cpuRespValid,
    output logic                      cpuRespHit,
    output logic [BLK-1:0]            cpuRespData,
    input  logic                      prefetchEn,
    input  logic                      prefetchStart,
    input  logic [BA_ADDR_SIZE-1:0]   prefetchBase,
    input  logic [BA_ADDR_SIZE-1:0]   prefetchStride,
    input  logic [LOG_QUEUE_SIZE:0]   maxOutstanding,
    output logic                      arValid,
    output logic [BA_ADDR_SIZE-1:0]   arAddr,
    input  logic                      arReady,
    input  logic                      rValid,
    input  logic [BA_ADDR_SIZE-1:0]   rAddr,
    input  logic [BLK-1:0]            rData,
    output logic                      rReady,
    output logic [1:0]                qOpcode,
    output logic [BA_ADDR_SIZE-1:0]   qAddr,
    output logic [BLK-1:0]            qData,
    input  logic                      qValid,
    input  logic                      qDataValid,
    input  logic [BLK-1:0]            qDataOut,
    input  logic [LOG_QUEUE_SIZE:0]   qOutstandingCnt,
    input  logic                      qAlmostFull,
    output logic [CNT_WIDTH-1:0]      hitCnt,
    output logic [CNT_WIDTH-1:0]      missCnt
);

    typedef enum logic [1:0] {PF_IDLE, PF_ISSUE, PF_WAIT_AR} pf_state_t;

    localparam logic [1:0] OP_INVAL = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WREQ  = 2'd2;
    localparam logic [1:0] OP_WRESP = 2'd3;

    localparam logic [BA_ADDR_SIZE-1:0] ALIGN_MASK =
        ~{{(BA_ADDR_SIZE-LOG_BLOCK_DATA_BYTES){1'b0}}, {LOG_BLOCK_DATA_BYTES{1'b1}}};

    function automatic logic [BA_ADDR_SIZE-1:0] align(input logic [BA_ADDR_SIZE-1:0] a);
        return a & ALIGN_MASK;
    endfunction

    pf_state_t                state, state_nxt;
    logic [BA_ADDR_SIZE-1:0]  next_addr;
    logic                     reload_pend;
    logic [BA_ADDR_SIZE-1:0]  reload_pend_addr;

    logic                     r_slot, cpu_slot, cpu_hit, cpu_miss, can_issue;
    logic                     start_reload, reload;
    logic [BA_ADDR_SIZE-1:0]  miss_addr, reload_addr;

    assign r_slot   = resetN & rValid;
    assign cpu_slot = resetN & cpuReqValid & ~rValid;
    assign cpu_hit  = cpu_slot & qValid & qDataValid;
    assign cpu_miss = cpu_slot & ~qValid;

    assign cpuReqReady = cpu_hit | cpu_miss;
    assign rReady      = resetN;

    // A start pulse in ISSUE blocks issue so the old stream address never leaks out after the reload.
    assign can_issue = (state == PF_ISSUE) & prefetchEn & ~prefetchStart & ~r_slot & ~cpu_slot
                     & (qOutstandingCnt < maxOutstanding) & ~qAlmostFull;

    assign miss_addr    = align(cpuReqAddr) + prefetchStride;
    assign start_reload = prefetchStart & (state != PF_IDLE);
    assign reload       = start_reload | cpu_miss;
    assign reload_addr  = start_reload ? align(prefetchBase) : miss_addr;

    always_comb begin
        qOpcode = OP_INVAL;
        qAddr   = '1;
        qData   = '0;
        if (r_slot) begin
            qOpcode = OP_WRESP;
            qAddr   = align(rAddr);
            qData   = rData;
        end else if (cpu_slot) begin
            qOpcode = OP_READ;
            qAddr   = align(cpuReqAddr);
        end else if (can_issue) begin
            qOpcode = OP_WREQ;
            qAddr   = align(next_addr);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PF_IDLE:    if (prefetchStart && prefetchEn) state_nxt = PF_ISSUE;
            PF_ISSUE:   if (!prefetchEn) state_nxt = PF_IDLE;
                        else if (can_issue) state_nxt = PF_WAIT_AR;
            PF_WAIT_AR: if (arReady) state_nxt = prefetchEn ? PF_ISSUE : PF_IDLE;
            default:    state_nxt = PF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= PF_IDLE;
            next_addr        <= '0;
            reload_pend      <= 1'b0;
            reload_pend_addr <= '0;
            arValid          <= 1'b0;
            arAddr           <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                PF_IDLE: begin
                    if (prefetchStart && prefetchEn) next_addr <= align(prefetchBase);
                    else if (cpu_miss)               next_addr <= miss_addr;
                end
                PF_ISSUE: begin
                    if (reload) next_addr <= reload_addr;
                end
                PF_WAIT_AR: begin
                    // Reloads seen while the AR is in flight are parked and override the stride step.
                    if (arReady) begin
                        reload_pend <= 1'b0;
                        if (reload)           next_addr <= reload_addr;
                        else if (reload_pend) next_addr <= reload_pend_addr;
                        else                  next_addr <= next_addr + prefetchStride;
                    end else if (reload) begin
                        reload_pend      <= 1'b1;
                        reload_pend_addr <= reload_addr;
                    end
                end
                default: ;
            endcase
            if (can_issue) begin
                arValid <= 1'b1;
                arAddr  <= align(next_addr);
            end else if (state == PF_WAIT_AR && arReady) begin
                arValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cpuRespValid <= 1'b0;
            cpuRespHit   <= 1'b0;
            cpuRespData  <= '0;
            hitCnt       <= '0;
            missCnt      <= '0;
        end else begin
            cpuRespValid <= cpuReqReady;
            cpuRespHit   <= cpu_hit;
            cpuRespData  <= cpu_hit ? qDataOut : '0;
            if (cpu_hit && hitCnt != '1)   hitCnt  <= hitCnt + CNT_WIDTH'(1);
            if (cpu_miss && missCnt != '1) missCnt <= missCnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_prefetcher_queue_ctrl.sv
// Bench for prefetcher_queue_ctrl: emulates the queue, drives AXI/CPU stimulus, checks against a block-level reference.
module tb_prefetcher_queue_ctrl;
    localparam int AW = 64, LB = 6, LQ = 6, CW = 32, BLK = 512, QN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            resetN, cpuReqValid, cpuReqReady, cpuRespValid, cpuRespHit;
    logic [AW-1:0]   cpuReqAddr, prefetchBase, prefetchStride, arAddr, rAddr, qAddr;
    logic [BLK-1:0]  cpuRespData, rData, qData, qDataOut;
    logic            prefetchEn, prefetchStart, arValid, arReady, rValid, rReady;
    logic [LQ:0]     maxOutstanding, qOutstandingCnt;
    logic [1:0]      qOpcode;
    logic            qValid, qDataValid, qAlmostFull;
    logic [CW-1:0]   hitCnt, missCnt;

    prefetcher_queue_ctrl #(.BA_ADDR_SIZE(AW), .LOG_BLOCK_DATA_BYTES(LB), .LOG_QUEUE_SIZE(LQ), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetN(resetN),
        .cpuReqValid(cpuReqValid), .cpuReqAddr(cpuReqAddr), .cpuReqReady(cpuReqReady),
        .cpuRespValid(cpuRespValid), .cpuRespHit(cpuRespHit), .cpuRespData(cpuRespData),
        .prefetchEn(prefetchEn), .prefetchStart(prefetchStart), .prefetchBase(prefetchBase),
        .prefetchStride(prefetchStride), .maxOutstanding(maxOutstanding),
        .arValid(arValid), .arAddr(arAddr), .arReady(arReady),
        .rValid(rValid), .rAddr(rAddr), .rData(rData), .rReady(rReady),
        .qOpcode(qOpcode), .qAddr(qAddr), .qData(qData),
        .qValid(qValid), .qDataValid(qDataValid), .qDataOut(qDataOut),
        .qOutstandingCnt(qOutstandingCnt), .qAlmostFull(qAlmostFull),
        .hitCnt(hitCnt), .missCnt(missCnt)
    );

    int errors = 0, checks = 0, exp_hits = 0, exp_miss = 0, cyc = 0;

    // Queue emulation: small associative store keyed by block address.
    logic [AW-1:0]  qe_addr [QN];
    logic           qe_used [QN];
    logic           qe_dv   [QN];
    logic [BLK-1:0] qe_data [QN];
    int             qe_wp = 0;
    logic           q_clr = 1'b1;
    logic           ovr_en = 1'b0;
    logic [LQ:0]    ovr_val = '0;
    int             ost_n;

    always_comb begin
        qValid = 1'b0; qDataValid = 1'b0; qDataOut = '0;
        for (int i = 0; i < QN; i++)
            if (qe_used[i] === 1'b1 && qe_addr[i] == qAddr) begin
                qValid = 1'b1; qDataValid = qe_dv[i]; qDataOut = qe_data[i];
            end
    end

    always_comb begin
        ost_n = 0;
        for (int i = 0; i < QN; i++)
            if (qe_used[i] === 1'b1 && qe_dv[i] === 1'b0) ost_n++;
        qOutstandingCnt = ovr_en ? ovr_val : (LQ+1)'(ost_n);
    end

    always @(posedge clk) begin
        if (q_clr) begin
            for (int i = 0; i < QN; i++) begin qe_used[i] <= 1'b0; qe_dv[i] <= 1'b0; end
            qe_wp <= 0;
        end else if (resetN) begin
            if (qOpcode == 2'd2 && !qValid) begin
                qe_used[qe_wp] <= 1'b1; qe_addr[qe_wp] <= qAddr; qe_dv[qe_wp] <= 1'b0;
                qe_wp <= (qe_wp + 1) % QN;
            end else if (qOpcode == 2'd3) begin
                for (int i = 0; i < QN; i++)
                    if (qe_used[i] && qe_addr[i] == qAddr) begin qe_dv[i] <= 1'b1; qe_data[i] <= qData; end
            end
        end
    end

    // Event log of writeReq slots and AR handshakes with their cycle numbers.
    logic [AW-1:0] wreq_q [$];
    logic [AW-1:0] ar_q [$];
    int            wreq_c [$];
    int            ar_c [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (resetN) begin
            if (qOpcode == 2'd2) begin wreq_q.push_back(qAddr); wreq_c.push_back(cyc); end
            if (arValid && arReady) begin ar_q.push_back(arAddr); ar_c.push_back(cyc); end
        end
    end

    bit             ref_in [logic [AW-1:0]];
    bit             ref_dv [logic [AW-1:0]];
    logic [BLK-1:0] ref_dat [logic [AW-1:0]];

    function automatic logic [BLK-1:0] rand_blk();
        logic [BLK-1:0] r;
        for (int i = 0; i < BLK/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_logs();
        wreq_q.delete(); ar_q.delete(); wreq_c.delete(); ar_c.delete();
    endtask

    task automatic start_stream(input logic [AW-1:0] base, input logic [AW-1:0] stride);
        @(negedge clk);
        prefetchBase = base; prefetchStride = stride; prefetchEn = 1'b1; prefetchStart = 1'b1;
        @(negedge clk);
        prefetchStart = 1'b0;
    endtask

    task automatic wait_arvalid(input string tag);
        int n = 0;
        while (arValid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (arValid !== 1'b1) begin errors++; $display("FAIL %s_arvalid_timeout got=%b want=1", tag, arValid); end
    endtask

    task automatic test_reset();
        resetN = 1'b0; q_clr = 1'b1; ovr_en = 1'b0;
        prefetchEn = 1'b0; prefetchStart = 1'b0; prefetchBase = '0; prefetchStride = '0;
        maxOutstanding = 7'd8; arReady = 1'b0; qAlmostFull = 1'b0;
        rValid = 1'b1; rAddr = 64'h1234; rData = rand_blk();
        cpuReqValid = 1'b1; cpuReqAddr = 64'h5678;
        exp_hits = 0; exp_miss = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (arValid !== 1'b0) begin errors++; $display("FAIL reset_arValid got=%b want=0", arValid); end
        checks++; if (arAddr !== '0) begin errors++; $display("FAIL reset_arAddr got=%h want=0", arAddr); end
        checks++; if (rReady !== 1'b0) begin errors++; $display("FAIL reset_rReady got=%b want=0", rReady); end
        checks++; if (cpuReqReady !== 1'b0) begin errors++; $display("FAIL reset_cpuReqReady got=%b want=0", cpuReqReady); end
        checks++; if (cpuRespValid !== 1'b0 || cpuRespHit !== 1'b0 || cpuRespData !== '0) begin
            errors++; $display("FAIL reset_resp got=%b/%b want=0/0", cpuRespValid, cpuRespHit); end
        checks++; if (hitCnt !== '0 || missCnt !== '0) begin errors++; $display("FAIL reset_counters got=%0d/%0d want=0/0", hitCnt, missCnt); end
        checks++; if (qOpcode !== 2'd0 || qAddr !== {AW{1'b1}} || qData !== '0) begin
            errors++; $display("FAIL reset_nop got=op%0d addr=%h want=op0 addr=all-ones", qOpcode, qAddr); end
        rValid = 1'b0; cpuReqValid = 1'b0; q_clr = 1'b0; resetN = 1'b1;
        @(negedge clk); #1;
        checks++; if (rReady !== 1'b1) begin errors++; $display("FAIL post_reset_rReady got=%b want=1", rReady); end
        checks++; if (qOpcode !== 2'd0 || qAddr !== {AW{1'b1}}) begin errors++; $display("FAIL idle_nop got=op%0d addr=%h", qOpcode, qAddr); end
    endtask

    task automatic test_stream();
        int n = 0;
        clear_logs(); arReady = 1'b1;
        start_stream(64'h1000, 64'h40);
        while (ar_q.size() < 3 && n < 40) begin @(negedge clk); n++; end
        prefetchEn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ar_q.size() != 3 || wreq_q.size() != 3) begin
            errors++; $display("FAIL stream_count got=ar%0d/wreq%0d want=3/3", ar_q.size(), wreq_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                logic [AW-1:0] e;
                e = 64'h1000 + 64'(k) * 64'h40;
                checks++; if (ar_q[k] !== e) begin errors++; $display("FAIL stream_ar%0d got=%h want=%h", k, ar_q[k], e); end
                checks++; if (wreq_q[k] !== e) begin errors++; $display("FAIL stream_wreq%0d got=%h want=%h", k, wreq_q[k], e); end
                checks++; if (ar_c[k] != wreq_c[k] + 1) begin errors++; $display("FAIL stream_latency%0d got=%0d want=%0d", k, ar_c[k], wreq_c[k] + 1); end
            end
        end
    endtask

    task automatic test_hit();
        logic [BLK-1:0] d;
        d = rand_blk();
        @(negedge clk);
        rValid = 1'b1; rAddr = 64'h1040; rData = d; #1;
        checks++; if (qOpcode !== 2'd3 || qAddr !== 64'h1040 || qData !== d) begin
            errors++; $display("FAIL hit_rslot got=op%0d addr=%h want=op3 addr=1040", qOpcode, qAddr); end
        @(negedge clk);
        rValid = 1'b0; cpuReqValid = 1'b1; cpuReqAddr = 64'h106a; #1;
        checks++; if (cpuReqReady !== 1'b1 || qOpcode !== 2'd1 || qAddr !== 64'h1040) begin
            errors++; $display("FAIL hit_accept got=rdy%b op%0d addr=%h want=rdy1 op1 addr=1040", cpuReqReady, qOpcode, qAddr); end
        @(negedge clk);
        cpuReqValid = 1'b0; exp_hits++; #1;
        checks++; if (cpuRespValid !== 1'b1 || cpuRespHit !== 1'b1 || cpuRespData !== d) begin
            errors++; $display("FAIL hit_resp got=v%b h%b data=%h want=v1 h1 data=%h", cpuRespValid, cpuRespHit, cpuRespData, d); end
        checks++; if (hitCnt !== CW'(exp_hits)) begin errors++; $display("FAIL hit_cnt got=%0d want=%0d", hitCnt, exp_hits); end
        @(negedge clk); #1;
        checks++; if (cpuRespValid !== 1'b0) begin errors++; $display("FAIL hit_pulse got=%b want=0", cpuRespValid); end
    endtask

    task automatic test_outstanding();
        logic [BLK-1:0] d;
        d = rand_blk();
        @(negedge clk);
        cpuReqValid = 1'b1; cpuReqAddr = 64'h1080;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (cpuReqReady !== 1'b0) begin errors++; $display("FAIL ost_stall%0d got=%b want=0", i, cpuReqReady); end
            @(negedge clk);
        end
        checks++; if (cpuRespValid !== 1'b0) begin errors++; $display("FAIL ost_noresp got=%b want=0", cpuRespValid); end
        rValid = 1'b1; rAddr = 64'h1080; rData = d; #1;
        checks++; if (cpuReqReady !== 1'b0 || qOpcode !== 2'd3) begin
            errors++; $display("FAIL ost_rwins got=rdy%b op%0d want=rdy0 op3", cpuReqReady, qOpcode); end
        @(negedge clk);
        rValid = 1'b0; #1;
        checks++; if (cpuReqReady !== 1'b1) begin errors++; $display("FAIL ost_retry got=%b want=1", cpuReqReady); end
        @(negedge clk);
        cpuReqValid = 1'b0; exp_hits++; #1;
        checks++; if (cpuRespHit !== 1'b1 || cpuRespData !== d || hitCnt !== CW'(exp_hits)) begin
            errors++; $display("FAIL ost_hit got=h%b cnt=%0d want=h1 cnt=%0d", cpuRespHit, hitCnt, exp_hits); end
    endtask

    task automatic test_miss();
        int n = 0;
        clear_logs(); arReady = 1'b0;
        start_stream(64'h2000, 64'h40);
        wait_arvalid("miss");
        cpuReqValid = 1'b1; cpuReqAddr = 64'h9000; #1;
        checks++; if (cpuReqReady !== 1'b1) begin errors++; $display("FAIL miss_accept got=%b want=1", cpuReqReady); end
        @(negedge clk);
        cpuReqValid = 1'b0; exp_miss++; #1;
        checks++; if (cpuRespValid !== 1'b1 || cpuRespHit !== 1'b0 || cpuRespData !== '0) begin
            errors++; $display("FAIL miss_resp got=v%b h%b want=v1 h0", cpuRespValid, cpuRespHit); end
        checks++; if (missCnt !== CW'(exp_miss)) begin errors++; $display("FAIL miss_cnt got=%0d want=%0d", missCnt, exp_miss); end
        arReady = 1'b1;
        while (ar_q.size() < 2 && n < 20) begin @(negedge clk); n++; end
        prefetchEn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ar_q.size() != 2) begin errors++; $display("FAIL miss_ar_count got=%0d want=2", ar_q.size()); end
        else if (ar_q[0] !== 64'h2000 || ar_q[1] !== 64'h9040) begin
            errors++; $display("FAIL miss_reload got=%h,%h want=2000,9040", ar_q[0], ar_q[1]); end
    endtask

    task automatic test_throttle();
        int n = 0;
        clear_logs(); arReady = 1'b1; qAlmostFull = 1'b1;
        start_stream(64'h3000, 64'h40);
        repeat (8) @(negedge clk);
        checks++; if (wreq_q.size() != 0 || arValid !== 1'b0) begin
            errors++; $display("FAIL throttle_full got=wreq%0d arv%b want=0/0", wreq_q.size(), arValid); end
        qAlmostFull = 1'b0; ovr_en = 1'b1; ovr_val = 7'd2; maxOutstanding = 7'd2;
        repeat (8) @(negedge clk);
        checks++; if (wreq_q.size() != 0) begin errors++; $display("FAIL throttle_limit got=%0d want=0", wreq_q.size()); end
        ovr_val = 7'd0; maxOutstanding = 7'd0;
        repeat (8) @(negedge clk);
        checks++; if (wreq_q.size() != 0) begin errors++; $display("FAIL throttle_zero got=%0d want=0", wreq_q.size()); end
        ovr_en = 1'b0; maxOutstanding = 7'd8;
        while (ar_q.size() < 1 && n < 20) begin @(negedge clk); n++; end
        prefetchEn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ar_q.size() != 1 || wreq_q.size() != 1) begin
            errors++; $display("FAIL throttle_resume got=ar%0d wreq%0d want=1/1", ar_q.size(), wreq_q.size()); end
        else if (ar_q[0] !== 64'h3000 || wreq_q[0] !== 64'h3000) begin
            errors++; $display("FAIL throttle_addr got=%h want=3000", ar_q[0]); end
    endtask

    task automatic test_ar_hold();
        clear_logs(); arReady = 1'b0;
        start_stream(64'h4000, 64'h40);
        wait_arvalid("hold");
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (arValid !== 1'b1 || arAddr !== 64'h4000) begin
                errors++; $display("FAIL hold_stable%0d got=v%b addr=%h want=v1 addr=4000", i, arValid, arAddr); end
            if (i == 2) prefetchEn = 1'b0;
            @(negedge clk);
        end
        arReady = 1'b1;
        @(negedge clk);
        arReady = 1'b0; #1;
        checks++; if (arValid !== 1'b0 || ar_q.size() != 1) begin
            errors++; $display("FAIL hold_handshake got=v%b n%0d want=v0 n1", arValid, ar_q.size()); end
        prefetchEn = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (wreq_q.size() != 1) begin errors++; $display("FAIL hold_idle got=%0d want=1", wreq_q.size()); end
        prefetchEn = 1'b0;
        start_stream(64'h4400, 64'h40);
        wait_arvalid("rst");
        checks++; if (arAddr !== 64'h4400) begin errors++; $display("FAIL rst_araddr got=%h want=4400", arAddr); end
        #2 resetN = 1'b0; exp_hits = 0; exp_miss = 0; #1;
        checks++; if (arValid !== 1'b0 || arAddr !== '0 || hitCnt !== '0 || missCnt !== '0) begin
            errors++; $display("FAIL rst_async got=v%b addr=%h hit=%0d want=v0 addr=0 hit=0", arValid, arAddr, hitCnt); end
        prefetchEn = 1'b0;
        @(negedge clk);
        resetN = 1'b1; arReady = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (arValid !== 1'b0 || ar_q.size() != 1 || wreq_q.size() != 2) begin
            errors++; $display("FAIL rst_abandon got=v%b ar%0d wreq%0d want=v0 ar1 wreq2", arValid, ar_q.size(), wreq_q.size()); end
    endtask

    task automatic test_random_lookup();
        logic [AW-1:0]  strides [4];
        logic [AW-1:0]  list [8];
        logic [AW-1:0]  base, stride, a, ra;
        logic [BLK-1:0] rd, exp_d;
        bit             do_r, do_c, exp_rdy, exp_h;
        int             n = 0;
        strides[0] = 64'h40; strides[1] = 64'hFFFF_FFFF_FFFF_FFC0; strides[2] = 64'h80; strides[3] = 64'h1C0;
        stride = strides[$urandom_range(0, 3)];
        base = 64'h0000_00A0_0000_0000 + (64'($urandom_range(0, 1023)) << 6);
        for (int k = 0; k < 8; k++) list[k] = base + 64'(k) * stride;
        @(negedge clk); q_clr = 1'b1;
        @(negedge clk); q_clr = 1'b0;
        clear_logs(); maxOutstanding = 7'd16;
        start_stream(base | 64'($urandom_range(0, 63)), stride);
        while (ar_q.size() < 8 && n < 400) begin arReady = $urandom_range(0, 1) == 1; @(negedge clk); n++; end
        prefetchEn = 1'b0; arReady = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ar_q.size() != 8 || wreq_q.size() != 8) begin
            errors++; $display("FAIL rand_stream_count got=ar%0d wreq%0d want=8/8", ar_q.size(), wreq_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++; if (ar_q[k] !== list[k] || wreq_q[k] !== list[k]) begin
                    errors++; $display("FAIL rand_stream%0d got=%h/%h want=%h", k, ar_q[k], wreq_q[k], list[k]); end
            end
        end
        ref_in.delete(); ref_dv.delete(); ref_dat.delete();
        for (int k = 0; k < 8; k++) ref_in[list[k]] = 1'b1;
        for (int it = 0; it < 250; it++) begin
            do_r = $urandom_range(0, 2) == 0;
            do_c = $urandom_range(0, 3) != 0;
            ra = ($urandom_range(0, 3) != 0) ? list[$urandom_range(0, 7)]
                                              : 64'h7000_0000_0000_0000 + (64'($urandom_range(0, 63)) << 6);
            a  = ($urandom_range(0, 9) < 7) ? list[$urandom_range(0, 7)]
                                             : 64'h6000_0000 + (64'($urandom_range(0, 255)) << 6);
            rd = rand_blk();
            rValid = do_r; rAddr = ra; rData = rd;
            cpuReqValid = do_c; cpuReqAddr = a | 64'($urandom_range(0, 63));
            #1;
            exp_rdy = do_c && !do_r && (!ref_in.exists(a) || ref_dv.exists(a));
            checks++; if (cpuReqReady !== exp_rdy) begin
                errors++; $display("FAIL rand_ready it%0d got=%b want=%b addr=%h", it, cpuReqReady, exp_rdy, a); end
            exp_h = exp_rdy && ref_in.exists(a);
            exp_d = exp_h ? ref_dat[a] : '0;
            if (exp_rdy) begin if (exp_h) exp_hits++; else exp_miss++; end
            @(negedge clk);
            checks++; if (cpuRespValid !== exp_rdy || cpuRespHit !== exp_h || cpuRespData !== exp_d) begin
                errors++; $display("FAIL rand_resp it%0d got=v%b h%b want=v%b h%b", it, cpuRespValid, cpuRespHit, exp_rdy, exp_h); end
            if (do_r && ref_in.exists(ra)) begin ref_dv[ra] = 1'b1; ref_dat[ra] = rd; end
        end
        rValid = 1'b0; cpuReqValid = 1'b0;
        @(negedge clk); #1;
        checks++; if (hitCnt !== CW'(exp_hits) || missCnt !== CW'(exp_miss)) begin
            errors++; $display("FAIL rand_counters got=%0d/%0d want=%0d/%0d", hitCnt, missCnt, exp_hits, exp_miss); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_hit();
        test_outstanding();
        test_miss();
        test_throttle();
        test_ar_hold();
        test_random_lookup();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
